// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin ALU/load write-back arbiter with busy scoreboard
module regfile_wb_arbiter #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = 5
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            alu_valid,
  input  logic [AW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_ready,
  input  logic            mem_valid,
  input  logic [AW-1:0]   mem_rd,
  input  logic [XLEN-1:0] mem_data,
  output logic            mem_ready,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic            rd_busy,
  output logic [AW-1:0]   rf_rd,
  output logic [XLEN-1:0] rf_data,
  output logic            rf_reg_write
);

  typedef enum logic {PRI_MEM = 1'b0, PRI_ALU = 1'b1} pri_t;

  pri_t            r_state;
  pri_t            w_next;
  logic            w_alu_gnt;
  logic            w_mem_gnt;
  logic            w_gnt;
  logic [AW-1:0]   w_gnt_rd;
  logic [XLEN-1:0] w_gnt_data;
  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_busy_next;
  logic [AW-1:0]   r_rf_rd;
  logic [XLEN-1:0] r_rf_data;
  logic            r_rf_reg_write;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= PRI_MEM;
    end else begin
      r_state <= w_next;
    end
  end

  // Readys are forced low during reset so nothing is granted while it is held.
  always_comb begin
    w_alu_gnt = 1'b0;
    w_mem_gnt = 1'b0;
    w_next    = r_state;
    if (reset_n) begin
      case (r_state)
        PRI_MEM: begin
          if (mem_valid)      w_mem_gnt = 1'b1;
          else if (alu_valid) w_alu_gnt = 1'b1;
        end
        PRI_ALU: begin
          if (alu_valid)      w_alu_gnt = 1'b1;
          else if (mem_valid) w_mem_gnt = 1'b1;
        end
        default: ;
      endcase
      if (w_alu_gnt)      w_next = PRI_MEM;
      else if (w_mem_gnt) w_next = PRI_ALU;
    end
  end

  assign alu_ready  = w_alu_gnt;
  assign mem_ready  = w_mem_gnt;
  assign w_gnt      = w_alu_gnt | w_mem_gnt;
  assign w_gnt_rd   = w_mem_gnt ? mem_rd   : alu_rd;
  assign w_gnt_data = w_mem_gnt ? mem_data : alu_data;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rf_rd        <= '0;
      r_rf_data      <= '0;
      r_rf_reg_write <= 1'b0;
    end else begin
      r_rf_reg_write <= w_gnt && (w_gnt_rd != '0);
      if (w_gnt) begin
        r_rf_rd   <= w_gnt_rd;
        r_rf_data <= w_gnt_data;
      end
    end
  end

  // Set is applied after clear so a newer producer keeps the register busy.
  always_comb begin
    w_busy_next = r_busy;
    if (w_gnt) w_busy_next[w_gnt_rd] = 1'b0;
    if (issue_valid) w_busy_next[issue_rd] = 1'b1;
    w_busy_next[0] = 1'b0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_next;
    end
  end

  assign rs1_busy     = r_busy[rs1];
  assign rs2_busy     = r_busy[rs2];
  assign rd_busy      = r_busy[issue_rd];
  assign rf_rd        = r_rf_rd;
  assign rf_data      = r_rf_data;
  assign rf_reg_write = r_rf_reg_write;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed vector bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

  logic        clock;
  logic        reset_n;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        mem_valid;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        mem_ready;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        rs1_busy;
  logic        rs2_busy;
  logic        rd_busy;
  logic [4:0]  rf_rd;
  logic [31:0] rf_data;
  logic        rf_reg_write;

  int total = 0;
  int bad   = 0;

  regfile_wb_arbiter #(.XLEN(32), .NREGS(32), .AW(5)) dut (
    .clock(clock), .reset_n(reset_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .rd_busy(rd_busy),
    .rf_rd(rf_rd), .rf_data(rf_data), .rf_reg_write(rf_reg_write)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        av;  logic [4:0] ard; logic [31:0] adat;
    logic        mv;  logic [4:0] mrd; logic [31:0] mdat;
    logic        iv;  logic [4:0] ird;
    logic [4:0]  r1;  logic [4:0] r2;
    logic        e_ar; logic e_mr; logic e_r1b; logic e_r2b; logic e_rdb;
    logic        e_we; logic [4:0] e_rd; logic [31:0] e_dat;
  } vec_t;

  vec_t vecs[19];

  function automatic vec_t mk(
    logic av, logic [4:0] ard, logic [31:0] adat,
    logic mv, logic [4:0] mrd, logic [31:0] mdat,
    logic iv, logic [4:0] ird, logic [4:0] r1, logic [4:0] r2,
    logic e_ar, logic e_mr, logic e_r1b, logic e_r2b, logic e_rdb,
    logic e_we, logic [4:0] e_rd, logic [31:0] e_dat);
    vec_t v;
    v.av = av; v.ard = ard; v.adat = adat;
    v.mv = mv; v.mrd = mrd; v.mdat = mdat;
    v.iv = iv; v.ird = ird; v.r1 = r1; v.r2 = r2;
    v.e_ar = e_ar; v.e_mr = e_mr; v.e_r1b = e_r1b; v.e_r2b = e_r2b; v.e_rdb = e_rdb;
    v.e_we = e_we; v.e_rd = e_rd; v.e_dat = e_dat;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    mem_valid = 0; mem_rd = 0; mem_data = 0;
    issue_valid = 0; issue_rd = 0; rs1 = 0; rs2 = 0;
  endtask

  initial begin
    //                 av ard adat          mv mrd mdat          iv ird r1  r2  ar mr r1b r2b rdb we rd  dat
    vecs[0]  = mk(0, 0, 32'h0,        0, 0,  32'h0,        1, 3,  3,  0,  0, 0, 0, 0, 0, 0, 0,  32'h0);
    vecs[1]  = mk(1, 3, 32'hDEADBEEF, 0, 0,  32'h0,        0, 0,  3,  0,  1, 0, 1, 0, 0, 1, 3,  32'hDEADBEEF);
    vecs[2]  = mk(0, 0, 32'h0,        0, 0,  32'h0,        0, 0,  3,  0,  0, 0, 0, 0, 0, 0, 3,  32'hDEADBEEF);
    vecs[3]  = mk(0, 0, 32'h0,        0, 0,  32'h0,        1, 7,  7,  0,  0, 0, 0, 0, 0, 0, 3,  32'hDEADBEEF);
    vecs[4]  = mk(0, 0, 32'h0,        0, 0,  32'h0,        1, 9,  7,  0,  0, 0, 1, 0, 0, 0, 3,  32'hDEADBEEF);
    vecs[5]  = mk(1, 7, 32'hA0000001, 1, 9,  32'hB0000001, 0, 0,  9,  7,  0, 1, 1, 1, 0, 1, 9,  32'hB0000001);
    vecs[6]  = mk(1, 7, 32'hA0000001, 1, 9,  32'hB0000002, 0, 0,  9,  7,  1, 0, 0, 1, 0, 1, 7,  32'hA0000001);
    vecs[7]  = mk(1, 7, 32'hA0000002, 1, 9,  32'hB0000002, 0, 0,  9,  7,  0, 1, 0, 0, 0, 1, 9,  32'hB0000002);
    vecs[8]  = mk(1, 7, 32'hA0000002, 1, 9,  32'hB0000003, 0, 0,  9,  7,  1, 0, 0, 0, 0, 1, 7,  32'hA0000002);
    vecs[9]  = mk(0, 0, 32'h0,        0, 0,  32'h0,        1, 12, 12, 0,  0, 0, 0, 0, 0, 0, 7,  32'hA0000002);
    vecs[10] = mk(0, 0, 32'h0,        1, 0,  32'h1234,     0, 0,  12, 0,  0, 1, 1, 0, 0, 0, 0,  32'h1234);
    vecs[11] = mk(0, 0, 32'h0,        0, 0,  32'h0,        0, 0,  12, 0,  0, 0, 1, 0, 0, 0, 0,  32'h1234);
    vecs[12] = mk(0, 0, 32'h0,        0, 0,  32'h0,        1, 4,  4,  0,  0, 0, 0, 0, 0, 0, 0,  32'h1234);
    vecs[13] = mk(1, 4, 32'h44444444, 0, 0,  32'h0,        1, 4,  4,  0,  1, 0, 1, 0, 1, 1, 4,  32'h44444444);
    vecs[14] = mk(0, 0, 32'h0,        0, 0,  32'h0,        0, 0,  4,  12, 0, 0, 1, 1, 0, 0, 4,  32'h44444444);
    vecs[15] = mk(0, 0, 32'h0,        1, 0,  32'h0,        0, 0,  0,  0,  0, 1, 0, 0, 0, 0, 0,  32'h0);
    vecs[16] = mk(1, 4, 32'h55555555, 1, 12, 32'hC0C0C0C0, 0, 0,  4,  0,  1, 0, 1, 0, 0, 1, 4,  32'h55555555);
    vecs[17] = mk(0, 0, 32'h0,        1, 12, 32'hC0C0C0C1, 0, 0,  12, 0,  0, 1, 1, 0, 0, 1, 12, 32'hC0C0C0C1);
    vecs[18] = mk(0, 0, 32'h0,        0, 0,  32'h0,        0, 0,  12, 4,  0, 0, 0, 0, 0, 0, 12, 32'hC0C0C0C1);

    idle();
    reset_n = 0;
    @(negedge clock);
    chk("rst_we", {31'b0, rf_reg_write}, 32'd0);
    chk("rst_rd", {27'b0, rf_rd}, 32'd0);
    chk("rst_data", rf_data, 32'd0);
    alu_valid = 1; mem_valid = 1; #1;
    chk("rst_ready", {30'b0, alu_ready, mem_ready}, 32'd0);
    idle();
    @(negedge clock);
    reset_n = 1;

    for (int i = 0; i < 19; i++) begin
      @(negedge clock);
      alu_valid = vecs[i].av; alu_rd = vecs[i].ard; alu_data = vecs[i].adat;
      mem_valid = vecs[i].mv; mem_rd = vecs[i].mrd; mem_data = vecs[i].mdat;
      issue_valid = vecs[i].iv; issue_rd = vecs[i].ird;
      rs1 = vecs[i].r1; rs2 = vecs[i].r2;
      #2;
      chk($sformatf("v%0d alu_ready", i), {31'b0, alu_ready}, {31'b0, vecs[i].e_ar});
      chk($sformatf("v%0d mem_ready", i), {31'b0, mem_ready}, {31'b0, vecs[i].e_mr});
      chk($sformatf("v%0d rs1_busy", i), {31'b0, rs1_busy}, {31'b0, vecs[i].e_r1b});
      chk($sformatf("v%0d rs2_busy", i), {31'b0, rs2_busy}, {31'b0, vecs[i].e_r2b});
      chk($sformatf("v%0d rd_busy", i), {31'b0, rd_busy}, {31'b0, vecs[i].e_rdb});
      @(posedge clock); #1;
      chk($sformatf("v%0d rf_we", i), {31'b0, rf_reg_write}, {31'b0, vecs[i].e_we});
      chk($sformatf("v%0d rf_rd", i), {27'b0, rf_rd}, {27'b0, vecs[i].e_rd});
      chk($sformatf("v%0d rf_data", i), rf_data, vecs[i].e_dat);
    end

    // Reset in the middle of an active grant, then first grant after release.
    @(negedge clock);
    idle();
    alu_valid = 1; alu_rd = 5; alu_data = 32'h00005555;
    issue_valid = 1; issue_rd = 6; rs1 = 6;
    @(posedge clock); #1;
    chk("mid_we_before", {31'b0, rf_reg_write}, 32'd1);
    chk("mid_busy_before", {31'b0, rs1_busy}, 32'd1);
    issue_valid = 0;
    #1 reset_n = 0;
    #1;
    chk("mid_we_reset", {31'b0, rf_reg_write}, 32'd0);
    chk("mid_rd_reset", {27'b0, rf_rd}, 32'd0);
    chk("mid_busy_reset", {31'b0, rs1_busy}, 32'd0);
    chk("mid_ready_reset", {30'b0, alu_ready, mem_ready}, 32'd0);
    @(posedge clock); #1;
    chk("mid_we_held", {31'b0, rf_reg_write}, 32'd0);
    @(negedge clock);
    mem_valid = 1; mem_rd = 8; mem_data = 32'h88888888;
    reset_n = 1;
    #1;
    chk("post_rst_mem_ready", {31'b0, mem_ready}, 32'd1);
    chk("post_rst_alu_ready", {31'b0, alu_ready}, 32'd0);
    @(posedge clock); #1;
    chk("post_rst_rf_rd", {27'b0, rf_rd}, 32'd8);
    chk("post_rst_rf_data", rf_data, 32'h88888888);
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Write-back controller for the 32-entry integer register file, which has one write port.
- Arbitrates between two write-back sources, the ALU and the load/memory unit, using round-robin priority.
- Drives the register file's `rd`, `data` and `reg_write` inputs from registered outputs.
- Keeps a per-register busy scoreboard so the issue stage can detect RAW/WAW hazards on in-flight destinations.

Parameters:
- XLEN, 32, data width of the register file and write-back buses
- NREGS, 32, number of architectural registers; x0 is hardwired zero
- AW, 5, register address width, equal to log2(NREGS)

Ports:
- clock  input  1  system clock; all state updates on rising edge
- reset_n  input  1  asynchronous active-low reset
- alu_valid  input  1  ALU write-back request
- alu_rd  input  AW  ALU destination register
- alu_data  input  XLEN  ALU result
- alu_ready  output  1  ALU request granted this cycle
- mem_valid  input  1  load-unit write-back request
- mem_rd  input  AW  load destination register
- mem_data  input  XLEN  load result
- mem_ready  output  1  load request granted this cycle
- issue_valid  input  1  instruction issued; its destination becomes busy
- issue_rd  input  AW  destination of the issued instruction
- rs1  input  AW  source 1 address to check
- rs2  input  AW  source 2 address to check
- rs1_busy  output  1  scoreboard bit for rs1
- rs2_busy  output  1  scoreboard bit for rs2
- rd_busy  output  1  scoreboard bit for issue_rd (WAW check)
- rf_rd  output  AW  register file write address
- rf_data  output  XLEN  register file write data
- rf_reg_write  output  1  register file write enable

Behaviour:
- Interface (already decided): one clock, `clock`. Reset `reset_n` is asynchronous and active-low.
- Reset values:
  - rf_reg_write=0, rf_rd=0, rf_data=0.
  - All busy bits 0.
  - Priority pointer = PRI_MEM.
  - alu_ready and mem_ready are 0 while reset_n=0.
- Reset mid-operation drops any in-flight grant; no register file write occurs for it.
- Handshake:
  - A source asserts valid with rd/data stable and holds them until it sees ready=1 in the same cycle.
  - The transfer completes on the rising edge where valid && ready.
  - ready is combinational from the valids and the pointer.
  - At most one ready is high per cycle.
- Arbiter FSM, two states:
  - PRI_MEM: mem wins if mem_valid; otherwise alu wins if alu_valid.
  - PRI_ALU: alu wins if alu_valid; otherwise mem wins if mem_valid.
  - After any grant, the pointer moves to the state favouring the non-granted source.
  - With no grant, the pointer holds.
  - Two simultaneously valid sources therefore alternate every cycle; neither starves.
- Write path, 1-cycle latency:
  - On a granted edge: rf_rd <= granted rd, rf_data <= granted data, rf_reg_write <= (granted rd != 0).
  - On a non-granted edge: rf_reg_write <= 0; rf_rd and rf_data hold.
  - A grant with rd=0 is accepted (ready=1), but no write is generated and the scoreboard is untouched.
- Scoreboard:
  - busy[issue_rd] is set on an edge with issue_valid && issue_rd != 0.
  - busy[r] is cleared on the edge where a grant for rd=r completes, i.e. the same edge that launches the rf write.
  - If set and clear hit the same register on the same edge, the set wins (a newer producer is pending).
  - busy[0] is always 0.
  - rs1_busy, rs2_busy and rd_busy are combinational reads of the current busy vector. There is no bypass of an edge that is about to clear the bit.
  - The issue stage must not issue to a busy rd; that is the issue stage's stall responsibility. This block does not check it.
- Register file data becomes readable the cycle after rf_reg_write=1 (edge-triggered write). Consumers must wait for busy=0 plus one cycle, or use an external forward path.

Test Plan:
- Reset: assert reset_n=0 mid-grant with alu_valid=1, alu_rd=5 -> rf_reg_write=0 immediately, all busy=0, both readys 0; after release, the first grant goes to mem if both are valid.
- Single source: issue_rd=3, then alu_valid=1, alu_rd=3, alu_data=0xDEADBEEF -> alu_ready=1 that cycle; next cycle rf_reg_write=1, rf_rd=3, rf_data=0xDEADBEEF; rs1=3 shows busy=1 until the grant edge, then 0.
- Contention: alu_valid and mem_valid held high for 4 cycles with distinct rd 7/9 and data streams -> grants alternate mem, alu, mem, alu; exactly 4 rf writes in order.
- x0 write: mem_valid=1, mem_rd=0, mem_data=0x1234 -> mem_ready=1, rf_reg_write stays 0, busy vector unchanged.
- Simultaneous set/clear: busy[4]=1; same cycle, alu grant for rd=4 and issue_valid with issue_rd=4 -> busy[4] remains 1 after the edge; rf write of rd=4 still occurs.
- Backpressure hold: mem_valid held 2 cycles while alu wins under PRI_ALU -> mem_ready=0 then 1; mem_data sampled only on the granted edge.
